alu_cmd_sequencer: RTL and testbench

//  Upstream command stage for the 8-bit ALU core (main). Accepts operand/opcode commands on a

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_cmd_fifo.sv | 48 ++++
 rtl/alu_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
//   SEL_*      : encodings of the ALU in_sel bus {persist, load, reset}
//   state_e    : sequencer FSM states
//   sel_for()  : in_sel value driven while the FSM sits in a given state
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned OPW_DEF   = 7;

    localparam logic [2:0] SEL_NONE    = 3'b000;
    localparam logic [2:0] SEL_RESET   = 3'b001;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_PERSIST = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_EMIT = 2'd3
    } state_e;

    function automatic logic [2:0] sel_for(input state_e s);
        case (s)
            ST_IDLE: return SEL_NONE;
            ST_LOAD: return SEL_LOAD;
            default: return SEL_PERSIST;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x DW, with full/empty flags.
//   clk, rst       : clock, asynchronous active-low reset
//   push_i/wdata_i : write strobe and entry (ignored while full)
//   pop_i          : read strobe (ignored while empty)
//   rdata_o        : head entry, valid while !empty_o
//   full_o/empty_o : occupancy flags
module alu_cmd_fifo #(
    parameter int unsigned DW    = 23,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command stage in front of the 8-bit ALU core.
//   clk, rst                      : clock, asynchronous active-low reset
//   on                            : allows the FSM to pop new commands
//   cmd_valid/cmd_ready           : command handshake (cmd_a, cmd_b, cmd_op)
//   alu_in_sel/num1/num2/out_sel  : drive the ALU
//   alu_out                       : ALU result
//   res_valid/res_ready           : result handshake (res_data, res_op)
//   err                           : one-cycle pulse when a non-one-hot opcode is dropped
//   busy                          : FIFO holds entries or a command is in flight
//
// state | meaning
// IDLE  | waiting for on && FIFO non-empty; pops and validates the head
// LOAD  | ALU loads num1/num2/out_sel
// WAIT  | ALU persists; counts down the ALU latency
// EMIT  | result presented until res_ready
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [OPW-1:0]   cmd_op,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [OPW-1:0]   alu_out_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [OPW-1:0]   res_op,
    output logic             err,
    output logic             busy
);
    localparam int unsigned DW = 2*WIDTH + OPW;
    localparam int unsigned CW = $clog2(LAT + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] num1_q, num1_d, num2_q, num2_d, res_data_q, res_data_d;
    logic [OPW-1:0]   op_q, op_d, res_op_q, res_op_d;
    logic [2:0]       sel_q, sel_d;
    logic             err_q, err_d;
    logic             run_q;

    logic             fifo_full, fifo_empty, push, pop;
    logic [DW-1:0]    head;
    logic [WIDTH-1:0] head_a, head_b;
    logic [OPW-1:0]   head_op;

    // run_q keeps cmd_ready low through reset and until the first clock after release.
    assign cmd_ready = run_q && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign {head_a, head_b, head_op} = head;

    alu_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({cmd_a, cmd_b, cmd_op}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        op_d       = op_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
        err_d      = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (on && !fifo_empty) begin
                    pop = 1'b1;
                    if ($countones(head_op) != 1) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        num1_d  = head_a;
                        num2_d  = head_b;
                        op_d    = head_op;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
                cnt_d   = CW'(LAT);
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_data_d = alu_out;
                    res_op_d   = op_q;
                    state_d    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // in_sel is registered from the next state so it lines up with state_q.
        sel_d = sel_for(state_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            num1_q     <= '0;
            num2_q     <= '0;
            op_q       <= '0;
            res_data_q <= '0;
            res_op_q   <= '0;
            err_q      <= 1'b0;
            sel_q      <= SEL_RESET;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            op_q       <= op_d;
            res_data_q <= res_data_d;
            res_op_q   <= res_op_d;
            err_q      <= err_d;
            sel_q      <= sel_d;
            run_q      <= 1'b1;
        end
    end

    assign alu_in_sel  = sel_q;
    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_out_sel = op_q;
    assign res_valid   = (state_q == ST_EMIT);
    assign res_data    = res_data_q;
    assign res_op      = res_op_q;
    assign err         = err_q;
    assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
    localparam int W = 8, OPW = 7, DEPTH = 4, LAT = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           on = 1'b0, cmd_valid = 1'b0, res_ready = 1'b0;
    logic [W-1:0]   cmd_a = '0, cmd_b = '0;
    logic [OPW-1:0] cmd_op = '0;
    logic           cmd_ready, res_valid, err, busy;
    logic [2:0]     alu_in_sel;
    logic [W-1:0]   alu_num1, alu_num2, alu_out, res_data;
    logic [OPW-1:0] alu_out_sel, res_op;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(W), .OPW(OPW), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .on(on), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .alu_in_sel(alu_in_sel),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
        .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .err(err), .busy(busy)
    );

    // Reference ALU behaviour: one op per one-hot opcode bit.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [6:0] op);
        case (op)
            7'b0000001: return 8'(a + b);
            7'b0000010: return 8'(a - b);
            7'b0000100: return a & b;
            7'b0001000: return a | b;
            7'b0010000: return a ^ b;
            7'b0100000: return 8'(a << 1);
            7'b1000000: return a >> 1;
            default:    return 8'h00;
        endcase
    endfunction

    // ALU core model with a one-cycle load-to-output latency.
    always @(posedge clk) begin
        if (alu_in_sel == 3'b001)      alu_out <= 8'h00;
        else if (alu_in_sel == 3'b010) alu_out <= alu_ref(alu_num1, alu_num2, alu_out_sel);
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: every accepted command must come back, in order, as either
    // an err pulse (illegal opcode) or a result equal to the reference ALU.
    typedef struct { logic [7:0] a; logic [7:0] b; logic [6:0] op; } cmd_t;
    cmd_t mq[$];
    cmd_t mc;
    int   n_res = 0, n_err = 0;

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
        end else begin
            chk("in_sel_onehot0", 32'($countones(alu_in_sel) <= 1), 32'd1);
            if (err) begin
                if (mq.size() == 0) chk("err_without_cmd", 32'd1, 32'd0);
                else begin
                    mc = mq.pop_front();
                    chk("err_on_illegal_op", 32'($countones(mc.op) != 1), 32'd1);
                    n_err++;
                end
            end
            if (res_valid && res_ready) begin
                if (mq.size() == 0) chk("res_without_cmd", 32'd1, 32'd0);
                else begin
                    mc = mq.pop_front();
                    chk("res_op_order", 32'(res_op), 32'(mc.op));
                    chk("res_data_model", 32'(res_data), 32'(alu_ref(mc.a, mc.b, mc.op)));
                    n_res++;
                end
            end
            if (cmd_valid && cmd_ready) mq.push_back('{cmd_a, cmd_b, cmd_op});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [6:0] op);
        bit ok;
        ok = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin ok = 1; tick(); break; end
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_count(input int target, input int budget, input string name);
        for (int i = 0; i < budget && (n_res + n_err) < target; i++) tick();
        chk(name, 32'(n_res + n_err), 32'(target));
    endtask

    typedef struct {
        logic [7:0] a; logic [7:0] b; logic [6:0] op; logic [7:0] exp; logic ill;
    } vec_t;
    vec_t vt[10];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, pushes, flag;
        logic [7:0] hold_d;
        logic [6:0] hold_o;

        vt[0] = '{8'h57, 8'h1A, 7'b0001000, 8'h5F, 1'b0};
        vt[1] = '{8'h57, 8'h1A, 7'b0000001, 8'h71, 1'b0};
        vt[2] = '{8'h10, 8'h20, 7'b0000010, 8'hF0, 1'b0};
        vt[3] = '{8'hF0, 8'h3C, 7'b0000100, 8'h30, 1'b0};
        vt[4] = '{8'hFF, 8'h0F, 7'b0010000, 8'hF0, 1'b0};
        vt[5] = '{8'h81, 8'h00, 7'b0100000, 8'h02, 1'b0};
        vt[6] = '{8'h81, 8'h00, 7'b1000000, 8'h40, 1'b0};
        vt[7] = '{8'h12, 8'h34, 7'b0000110, 8'h00, 1'b1};
        vt[8] = '{8'h12, 8'h34, 7'b0000000, 8'h00, 1'b1};
        vt[9] = '{8'hAA, 8'h55, 7'b0000001, 8'hFF, 1'b0};

        // Reset held with a command offered.
        #2 rst = 1'b0;
        cmd_valid = 1'b1; cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = 7'b0000001;
        repeat (3) tick();
        chk("rst_in_sel", 32'(alu_in_sel), 32'h1);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rel_in_sel", 32'(alu_in_sel), 32'h0);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rel_busy_no_push", 32'(busy), 32'h0);

        // Single commands with cycle-exact checks.
        on = 1'b1; res_ready = 1'b1;
        foreach (vt[k]) begin
            cmd_a = vt[k].a; cmd_b = vt[k].b; cmd_op = vt[k].op; cmd_valid = 1'b1;
            chk($sformatf("v%0d_ready", k), 32'(cmd_ready), 32'h1);
            tick();
            cmd_valid = 1'b0;
            tick();
            if (!vt[k].ill) begin
                chk($sformatf("v%0d_load_sel", k), 32'(alu_in_sel), 32'h2);
                chk($sformatf("v%0d_num1", k), 32'(alu_num1), 32'(vt[k].a));
                chk($sformatf("v%0d_num2", k), 32'(alu_num2), 32'(vt[k].b));
                chk($sformatf("v%0d_out_sel", k), 32'(alu_out_sel), 32'(vt[k].op));
                tick();
                chk($sformatf("v%0d_wait_sel", k), 32'(alu_in_sel), 32'h4);
                chk($sformatf("v%0d_wait_rv", k), 32'(res_valid), 32'h0);
                tick();
                chk($sformatf("v%0d_res_valid", k), 32'(res_valid), 32'h1);
                chk($sformatf("v%0d_res_data", k), 32'(res_data), 32'(vt[k].exp));
                chk($sformatf("v%0d_res_op", k), 32'(res_op), 32'(vt[k].op));
                tick();
                chk($sformatf("v%0d_done_rv", k), 32'(res_valid), 32'h0);
                chk($sformatf("v%0d_done_sel", k), 32'(alu_in_sel), 32'h0);
            end else begin
                chk($sformatf("v%0d_err", k), 32'(err), 32'h1);
                chk($sformatf("v%0d_no_load", k), 32'(alu_in_sel), 32'h0);
                tick();
                chk($sformatf("v%0d_err_once", k), 32'(err), 32'h0);
                chk($sformatf("v%0d_idle_sel", k), 32'(alu_in_sel), 32'h0);
                chk($sformatf("v%0d_idle_busy", k), 32'(busy), 32'h0);
            end
        end

        // Fill the FIFO with popping disabled, then drain.
        on = 1'b0; res_ready = 1'b0;
        base = n_res + n_err;
        for (int i = 0; i < 4; i++) push_cmd(8'(8'h20 + i), 8'(8'h03 * i), 7'(7'b1 << i));
        chk("fill_ready_low", 32'(cmd_ready), 32'h0);
        cmd_a = 8'hEE; cmd_b = 8'hEE; cmd_op = 7'b0000001; cmd_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("fill_5th_blocked", 32'(cmd_ready), 32'h0);
        end
        cmd_valid = 1'b0;
        on = 1'b1; res_ready = 1'b1;
        wait_count(base + 4, 60, "fill_drain_count");
        chk("fill_queue_empty", 32'(mq.size()), 32'd0);

        // Backpressure in EMIT while the FIFO refills.
        res_ready = 1'b0;
        base = n_res + n_err;
        push_cmd(8'hC3, 8'h0F, 7'b0000100);
        for (int i = 0; i < 20 && !res_valid; i++) tick();
        chk("bp_res_valid", 32'(res_valid), 32'h1);
        hold_d = res_data; hold_o = res_op;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) push_cmd(8'(8'h40 + i), 8'h01, 7'(7'b0000001 << i)); else tick();
            chk("bp_valid_held", 32'(res_valid), 32'h1);
            chk("bp_data_stable", 32'({hold_o, hold_d}), 32'({res_op, res_data}));
        end
        chk("bp_fifo_full", 32'(cmd_ready), 32'h0);
        res_ready = 1'b1;
        wait_count(base + 5, 80, "bp_drain_count");

        // Reset during WAIT with commands still queued.
        on = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(8'h77, 8'h11, 7'b0000010);
        on = 1'b1;
        for (int i = 0; i < 20 && !(alu_in_sel == 3'b100 && !res_valid); i++) tick();
        chk("abort_in_wait", 32'(alu_in_sel), 32'h4);
        #2 rst = 1'b0;
        #1;
        chk("abort_sel", 32'(alu_in_sel), 32'h1);
        chk("abort_num1", 32'(alu_num1), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ready", 32'(cmd_ready), 32'h0);
        tick();
        rst = 1'b1;
        flag = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid || err || busy) flag = 1;
        end
        chk("abort_no_stale", 32'(flag), 32'd0);

        // Randomised traffic against the scoreboard.
        base = n_res + n_err;
        pushes = 0;
        for (int cyc = 0; cyc < 3000 && pushes < 80; cyc++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            cmd_op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'(7'b1 << $urandom_range(0, 6));
            on = ($urandom_range(0, 4) != 0);
            res_ready = ($urandom_range(0, 9) < 7);
            if (cmd_valid && cmd_ready) pushes++;
            tick();
        end
        cmd_valid = 1'b0; on = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 300 && (busy || mq.size() != 0); i++) tick();
        chk("rand_drained", 32'(busy), 32'h0);
        chk("rand_queue_empty", 32'(mq.size()), 32'd0);
        chk("rand_all_returned", 32'(n_res + n_err - base), 32'(pushes));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
